secded16_decoder: RTL and testbench



---
 rtl/secded_pkg.sv | 28 ++
 rtl/secded16_syndrome.sv | 34 +++
 rtl/secded16_decoder.sv | 77 +++++++
 tb/tb_secded16_decoder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared types and helpers for the Hamming(16,11) SECDED decoder.
// Bit index of the code word equals its Hamming position; bit 0 is overall parity.
package secded_pkg;

  typedef enum logic [2:0] {
    RX_LO  = 3'd0,
    RX_HI  = 3'd1,
    DECODE = 3'd2,
    TX_LO  = 3'd3,
    TX_HI  = 3'd4
  } state_t;

  localparam logic [1:0] ST_CLEAN  = 2'b00;
  localparam logic [1:0] ST_SINGLE = 2'b01;
  localparam logic [1:0] ST_DOUBLE = 2'b10;

  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P4 = 4;
  localparam int P8 = 8;

  // Data sits at every non-power-of-two position above zero, in ascending order.
  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

endpackage

// File: rtl/secded16_syndrome.sv
// Combinational SECDED check: syndrome, overall parity, corrected data and status.
module secded16_syndrome
  import secded_pkg::*;
(
  input  logic [15:0] cw,
  output logic [3:0]  syndrome,
  output logic        parity,
  output logic [10:0] data,
  output logic [1:0]  status
);

  logic [15:0] fixed;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    syndrome = '0;
    for (int i = 1; i < 16; i++) begin
      if (cw[i]) syndrome = syndrome ^ 4'(i);
    end
    parity = ^cw;
    fixed  = cw;
    status = ST_CLEAN;
    if (parity) begin
      // Odd parity means one flip; a zero syndrome points at p0, which carries no data.
      status = ST_SINGLE;
      if (syndrome != 4'd0) fixed[syndrome] = ~cw[syndrome];
    end else if (syndrome != 4'd0) begin
      status = ST_DOUBLE;
    end
  end

  assign data = extract_data(fixed);

endmodule

// File: rtl/secded16_decoder.sv
// Streaming Hamming(16,11) SECDED decoder: two input bytes per word, two output bytes,
// per-word status and saturating single/double error counters.
module secded16_decoder
  import secded_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic [1:0]       out_status,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] double_cnt
);

  state_t      state;
  logic [15:0] cw;
  logic [10:0] data_q;
  logic [10:0] dec_data;
  logic [1:0]  dec_status;

  secded16_syndrome u_syndrome (
    .cw       (cw),
    .syndrome (),
    .parity   (),
    .data     (dec_data),
    .status   (dec_status)
  );

  assign in_ready  = (state == RX_LO) || (state == RX_HI);
  assign out_valid = (state == TX_LO) || (state == TX_HI);

  always_comb begin
    out_byte = 8'h00;
    if (state == TX_LO)      out_byte = data_q[7:0];
    else if (state == TX_HI) out_byte = {5'b0, data_q[10:8]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RX_LO;
      cw         <= '0;
      data_q     <= '0;
      out_status <= ST_CLEAN;
      single_cnt <= '0;
      double_cnt <= '0;
    end else begin
      case (state)
        RX_LO: if (in_valid) begin
          cw[7:0] <= in_byte;
          state   <= RX_HI;
        end
        RX_HI: if (in_valid) begin
          cw[15:8] <= in_byte;
          state    <= DECODE;
        end
        DECODE: begin
          data_q     <= dec_data;
          out_status <= dec_status;
          if (dec_status == ST_SINGLE && single_cnt != '1) single_cnt <= single_cnt + 1'b1;
          if (dec_status == ST_DOUBLE && double_cnt != '1) double_cnt <= double_cnt + 1'b1;
          state <= TX_LO;
        end
        TX_LO: if (out_ready) state <= TX_HI;
        TX_HI: if (out_ready) state <= RX_LO;
        default: state <= RX_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_secded16_decoder.sv
// Self-checking bench for secded16_decoder: directed corner words plus random words
// with 0/1/2 injected bit flips, checked against an encode-and-flip reference model.
module tb_secded16_decoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       out_ready;

  logic       in_ready, out_valid, in_ready2, out_valid2;
  logic [7:0] out_byte, out_byte2;
  logic [1:0] out_status, out_status2;
  logic [7:0] single_cnt, double_cnt;
  logic [1:0] single_cnt2, double_cnt2;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_single = 0, exp_double = 0, exp_single2 = 0, exp_double2 = 0;

  always #5 clk = ~clk;

  secded16_decoder #(.CNT_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_status(out_status),
    .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  secded16_decoder #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_byte(in_byte), .out_valid(out_valid2), .out_ready(out_ready),
    .out_byte(out_byte2), .out_status(out_status2),
    .single_cnt(single_cnt2), .double_cnt(double_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference encoder: data fills non-power-of-two positions, each parity covers positions sharing its bit.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    int k;
    w = '0;
    k = 0;
    for (int i = 3; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        w[i] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      for (int i = 1; i < 16; i++) begin
        if ((i & p) != 0 && i != p) w[p] = w[p] ^ w[i];
      end
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] raw_data(input logic [15:0] w);
    logic [10:0] d;
    int k;
    d = '0;
    k = 0;
    for (int i = 3; i < 16; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[k] = w[i];
        k++;
      end
    end
    return d;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic recv_byte(input int hold, output logic [7:0] b, output logic [1:0] st);
    int n;
    n = 0;
    out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    b  = out_byte;
    st = out_status;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic bump_counters(input logic [1:0] st);
    if (st == 2'b01) begin
      if (exp_single < 255) exp_single++;
      if (exp_single2 < 3) exp_single2++;
    end else if (st == 2'b10) begin
      if (exp_double < 255) exp_double++;
      if (exp_double2 < 3) exp_double2++;
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_single_cnt"}, 32'(single_cnt), 32'(exp_single));
    check({tag, "_double_cnt"}, 32'(double_cnt), 32'(exp_double));
    check({tag, "_single_cnt_w2"}, 32'(single_cnt2), 32'(exp_single2));
    check({tag, "_double_cnt_w2"}, 32'(double_cnt2), 32'(exp_double2));
  endtask

  task automatic do_word(input string tag, input logic [15:0] w, input logic [10:0] exp_d,
                         input logic [1:0] exp_st, input int hold);
    logic [7:0] b0, b1;
    logic [1:0] s0, s1;
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    recv_byte(hold, b0, s0);
    bump_counters(exp_st);
    check_counters(tag);
    recv_byte(hold, b1, s1);
    check({tag, "_lo"}, 32'(b0), 32'(exp_d[7:0]));
    check({tag, "_hi"}, 32'(b1), {29'd0, exp_d[10:8]});
    check({tag, "_status_lo"}, 32'(s0), 32'(exp_st));
    check({tag, "_status_hi"}, 32'(s1), 32'(exp_st));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_byte"}, 32'(out_byte), 32'd0);
    check({tag, "_out_status"}, 32'(out_status), 32'd0);
    check({tag, "_single_cnt"}, 32'(single_cnt), 32'd0);
    check({tag, "_double_cnt"}, 32'(double_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] hold_byte;
    logic [1:0] hold_st;
    logic [7:0] b0, b1;
    logic [1:0] s0, s1;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Directed words from the decode-outcome table.
    do_word("clean_ff", 16'hFFFF, 11'h7FF, 2'b00, 0);
    do_word("single_bit13", 16'hDFFF, 11'h7FF, 2'b01, 0);
    do_word("p0_only", 16'h0001, 11'h000, 2'b01, 0);
    do_word("double_s1", 16'h0003, 11'h000, 2'b10, 1);

    // Latency: DECODE cycle with out_valid low, then TX_LO.
    send_byte(8'hFF);
    send_byte(8'hFF);
    check("latency_decode_out_valid", 32'(out_valid), 32'd0);
    check("latency_decode_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("latency_tx_out_valid", 32'(out_valid), 32'd1);

    // Backpressure: hold out_ready low in TX_LO, the source offers a byte that must not move.
    hold_byte = out_byte;
    hold_st   = out_status;
    in_valid  = 1'b1;
    in_byte   = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_byte", 32'(out_byte), 32'hFF);
      check("bp_out_status", 32'(out_status), 32'(hold_st));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    check("bp_first_byte", 32'(hold_byte), 32'hFF);
    in_valid = 1'b0;
    recv_byte(0, b0, s0);
    recv_byte(0, b1, s1);
    check("bp_lo", 32'(b0), 32'hFF);
    check("bp_hi", 32'(b1), 32'h07);
    do_word("bp_next", 16'h0000, 11'h000, 2'b00, 0);

    // Saturation on the narrow counter.
    for (int i = 0; i < 5; i++) do_word("sat_single", 16'hDFFF, 11'h7FF, 2'b01, 0);

    // Random words with 0, 1 or 2 distinct flips.
    for (int n = 0; n < 200; n++) begin
      logic [10:0] d;
      logic [15:0] w;
      int flips, a, b;
      logic [1:0] st;
      logic [10:0] exp_d;
      d     = 11'($urandom);
      w     = encode(d);
      flips = $urandom_range(0, 2);
      a     = $urandom_range(0, 15);
      b     = (a + $urandom_range(1, 15)) % 16;
      if (flips >= 1) w[a] = ~w[a];
      if (flips == 2) w[b] = ~w[b];
      st    = (flips == 0) ? 2'b00 : (flips == 1) ? 2'b01 : 2'b10;
      exp_d = (flips == 2) ? raw_data(w) : d;
      do_word("rand", w, exp_d, st, $urandom_range(0, 2));
    end

    // Reset after the LSW has been accepted discards the word and clears counters.
    send_byte(8'h5A);
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    check_reset_state("mid_reset");
    exp_single = 0;
    exp_double = 0;
    exp_single2 = 0;
    exp_double2 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_word("after_reset", 16'h0000, 11'h000, 2'b00, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
